uart_rx_ctl: RTL and testbench
==============================

Name: uart_rx_ctl

Overview:
UART receive controller that sits directly upstream of the LED output stage and feeds its rx_data/rx_data_rdy inputs.
- Samples the asynchronous serial line at 16x oversampling.
- Frames 8N1 characters, LSB first.
- Presents each received byte with a one-cycle ready strobe in the clk_rx domain.
- Contains its own oversample-tick generator, so no external baud enable is needed.

Parameters:
CLOCK_RATE, 50_000_000, clk_rx frequency in Hz
BAUD_RATE, 115_200, serial bit rate in baud
OVERSAMPLE, 16, oversample ticks per bit; power of 2, minimum 8

Ports:
clk_rx  input  1  receive clock; all logic on its rising edge
rst_clk_rx_n  input  1  reset, asynchronous assert, active-low
rxd_i  input  1  raw asynchronous serial line; idles high
rx_data  output  8  last good received byte; valid while rx_data_rdy=1, held afterwards
rx_data_rdy  output  1  one-cycle strobe: new byte on rx_data
frame_err  output  1  one-cycle strobe: stop bit sampled low

Behaviour:
- Reset (rst_clk_rx_n=0, asynchronous):
  - Synchronizer flops = 1, state = IDLE, counters = 0.
  - rx_data = 8'h00, rx_data_rdy = 0, frame_err = 0.
- Synchronizer: two flops on rxd_i give rxd_s. Only rxd_s is used; it lags rxd_i by 2 cycles.
- Tick generator:
  - DIVIDER = CLOCK_RATE / (BAUD_RATE*OVERSAMPLE), integer-truncated; 27 at defaults.
  - Counter runs 0..DIVIDER-1 and emits a 1-cycle tick at DIVIDER-1.
  - Free-running from reset; never restarted by frame activity.
- os_cnt: 4-bit oversample counter (log2 OVERSAMPLE bits). Advances only on tick; wraps naturally.
- bit_cnt: 3-bit data bit counter.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on a tick with rxd_s=0, clear os_cnt and go to START.
  - START: on the tick where os_cnt = OVERSAMPLE/2-1 (mid start bit):
    - rxd_s=0: clear os_cnt and bit_cnt, go to DATA.
    - rxd_s=1: false start, return to IDLE; no output.
  - DATA: on each tick where os_cnt = OVERSAMPLE-1, shift rxd_s into the MSB of the shift register (LSB-first serial).
    - After bit_cnt=7 is sampled, go to STOP. Otherwise increment bit_cnt.
  - STOP: on the tick where os_cnt = OVERSAMPLE-1:
    - rxd_s=1: load rx_data from the shift register, pulse rx_data_rdy on the next cycle, go to IDLE.
    - rxd_s=0: pulse frame_err, leave rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with rxd_s=1, then go to IDLE. This prevents a break condition from retriggering frames.
- Latency: rx_data_rdy rises 1 clk_rx cycle after the mid-stop-bit sampling tick. rx_data is stable in that same cycle.
- rx_data_rdy and frame_err are never high together and never high for more than one cycle.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. IDLE is re-entered before the next start edge, within half a bit time.
- Asynchronous reset mid-frame aborts the frame. No strobe is issued and rx_data returns to 8'h00.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame becomes 8E1. State PARITY is inserted between DATA and STOP and samples one bit on the os_cnt=OVERSAMPLE-1 tick.
  - Adds output parity_err (1 bit), a one-cycle strobe in the same cycle rx_data_rdy would fire.
  - If the XOR of the 8 data bits and the parity bit is nonzero: rx_data is not loaded, rx_data_rdy stays 0, parity_err = 1.
  - If stop is also bad, frame_err takes priority and parity_err stays 0.
- Undefined: 8N1 as above; the parity_err port does not exist.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, STOP, PARITY, WAIT_HIGH).
  - DATA_BITS = 8.
  - Function computing DIVIDER and its counter width from CLOCK_RATE, BAUD_RATE and OVERSAMPLE.
- Sub-module uart_baud_gen:
  - Parameters CLOCK_RATE, BAUD_RATE, OVERSAMPLE.
  - Ports clk_rx, rst_clk_rx_n, baud_x16_en.
  - Instantiated once.
- Synchronizer, FSM and shift register stay in uart_rx_ctl.

Test Plan:
- Defaults; drive byte 0x55 (8N1, 8.68 us/bit) -> exactly one rx_data_rdy pulse with rx_data=0x55; frame_err stays 0.
- Frames 0xA5 then 0x3C with zero idle between them -> two rx_data_rdy pulses, ~86.8 us apart, with rx_data 0xA5 then 0x3C.
- rxd_i low for 3 us (less than half a bit), then high -> no strobe; next frame 0x81 received correctly.
- Frame 0xFF with stop bit 0, line held low 200 us, then high, then frame 0x12 -> one frame_err pulse; rx_data keeps its previous value; a single rx_data_rdy pulse with 0x12 and no extra frame_err.
- Assert rst_clk_rx_n low mid-way through data bit 4 of 0xC3 -> rx_data=0x00 immediately and no strobe. A full 0x7E frame sent after reset release and line idle -> 0x7E.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> rx_data_rdy, rx_data=0x07. Same byte with parity 0 -> parity_err pulse, no rx_data_rdy, rx_data unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receive-path types and tick generator sizing helpers.
// Used by the oversample tick generator and the receive FSM.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY,
    WAIT_HIGH
  } rx_state_e;

  function automatic int calc_divider(
    input int clock_rate,
    input int baud_rate,
    input int oversample
  );
    return clock_rate / (baud_rate * oversample);
  endfunction

  function automatic int calc_div_width(
    input int clock_rate,
    input int baud_rate,
    input int oversample
  );
    int div;
    div = calc_divider(clock_rate, baud_rate, oversample);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_ctl_if.sv
// uart_rx_ctl_if: received-byte bundle toward the LED output stage.
// parity_err exists only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
interface uart_rx_ctl_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_data_rdy;
  logic                 frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (
    output rx_data,
    output rx_data_rdy,
    output frame_err,
    output parity_err
  );

  modport slave (
    input rx_data,
    input rx_data_rdy,
    input frame_err,
    input parity_err
  );
`else
  modport master (
    output rx_data,
    output rx_data_rdy,
    output frame_err
  );

  modport slave (
    input rx_data,
    input rx_data_rdy,
    input frame_err
  );
`endif
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running oversample tick generator.
// Emits a one-cycle baud_x16_en every DIVIDER clk_rx cycles.
`timescale 1ns/1ps
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_rx,
  input  logic rst_clk_rx_n,
  output logic baud_x16_en
);

  localparam int DIV =
    calc_divider(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int CW =
    calc_div_width(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign baud_x16_en = (cnt == LAST);

  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) begin
      cnt <= '0;
    end else if (baud_x16_en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctl.sv
// uart_rx_ctl: 16x oversampled 8N1 UART receiver, LSB first.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
`timescale 1ns/1ps
module uart_rx_ctl
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic          clk_rx,
  input  logic          rst_clk_rx_n,
  input  logic          rxd_i,
  uart_rx_ctl_if.master rx
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_MID =
    OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_END =
    OSW'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic tick;
  logic rxd_m;
  logic rxd_s;
  logic samp;

  rx_state_e            state;
  rx_state_e            state_nx;
  logic [OSW-1:0]       os_cnt;
  logic [OSW-1:0]       os_nx;
  logic [2:0]           bit_cnt;
  logic [2:0]           bit_nx;
  logic [DATA_BITS-1:0] sh;
  logic [DATA_BITS-1:0] sh_nx;
  logic                 load;
  logic                 ferr;
`ifdef UART_RX_PARITY_EN
  logic                 par;
  logic                 par_nx;
  logic                 perr;
`endif

  uart_baud_gen #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_gen (
    .clk_rx       (clk_rx),
    .rst_clk_rx_n (rst_clk_rx_n),
    .baud_x16_en  (tick)
  );

  // Line idles high, so the synchronizer resets to 1.
  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd_i;
      rxd_s <= rxd_m;
    end
  end

  assign samp = tick && (os_cnt == OS_END);

  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      sh      <= '0;
`ifdef UART_RX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      os_cnt  <= os_nx;
      bit_cnt <= bit_nx;
      sh      <= sh_nx;
`ifdef UART_RX_PARITY_EN
      par     <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    os_nx    = tick ? os_cnt + 1'b1 : os_cnt;
    bit_nx   = bit_cnt;
    sh_nx    = sh;
    load     = 1'b0;
    ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nx   = par;
    perr     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (tick && !rxd_s) begin
          os_nx    = '0;
          state_nx = START;
        end
      end
      START: begin
        if (tick && os_cnt == OS_MID) begin
          if (!rxd_s) begin
            os_nx    = '0;
            bit_nx   = '0;
            state_nx = DATA;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (samp) begin
          sh_nx = {rxd_s, sh[DATA_BITS-1:1]};
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_nx = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (samp) begin
          par_nx   = rxd_s;
          state_nx = STOP;
        end
`else
        state_nx = IDLE;
`endif
      end
      STOP: begin
        if (samp) begin
          if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
            if (^{sh, par}) begin
              perr = 1'b1;
            end else begin
              load = 1'b1;
            end
`else
            load = 1'b1;
`endif
            state_nx = IDLE;
          end else begin
            ferr     = 1'b1;
            state_nx = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low break must not look like new start bits.
        if (tick && rxd_s) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
    if (!rst_clk_rx_n) begin
      rx.rx_data     <= '0;
      rx.rx_data_rdy <= 1'b0;
      rx.frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx.parity_err  <= 1'b0;
`endif
    end else begin
      if (load) begin
        rx.rx_data <= sh;
      end
      rx.rx_data_rdy <= load;
      rx.frame_err   <= ferr;
`ifdef UART_RX_PARITY_EN
      rx.parity_err  <= perr;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_ctl.sv
// tb_uart_rx_ctl: directed frames against an event-queue model.
// Each expected strobe is queued by the stimulus and consumed on negedge.
`timescale 1ns/1ps
module tb_uart_rx_ctl;

  localparam int BIT_CLKS = 434;
  localparam logic [1:0] K_RDY  = 2'd0;
  localparam logic [1:0] K_FERR = 2'd1;
  localparam logic [1:0] K_PERR = 2'd2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int rdy_seen  = 0;
  int ferr_seen = 0;
  int perr_seen = 0;
  logic prev_rdy  = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] model_data = 8'h00;
  logic [9:0] expq[$];
  int rdy_cyc[$];

  always #10 clk = ~clk;

  uart_rx_ctl_if rx ();

  uart_rx_ctl #(
    .CLOCK_RATE (50_000_000),
    .BAUD_RATE  (115_200),
    .OVERSAMPLE (16)
  ) dut (
    .clk_rx       (clk),
    .rst_clk_rx_n (rst_n),
    .rxd_i        (rxd),
    .rx           (rx)
  );

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic take(input logic [1:0] kind, input string name);
    logic [9:0] e;
    if (expq.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL %s: got unexpected strobe at cycle %0d, want none",
               name, cyc);
    end else begin
      e = expq.pop_front();
      chk(name, 32'(kind), 32'(e[9:8]));
      if (kind == K_RDY && e[9:8] == K_RDY) begin
        model_data = e[7:0];
      end
    end
  endtask

  // Compare process: strobes against queued events, rx_data every cycle.
  always @(negedge clk) begin
    logic any;
    int   nstb;
    cyc++;
    if (!rst_n) begin
      model_data = 8'h00;
      chk("rst_rx_data", 32'(rx.rx_data), 32'h0);
      chk("rst_rdy", 32'(rx.rx_data_rdy), 32'h0);
      chk("rst_ferr", 32'(rx.frame_err), 32'h0);
    end else begin
      nstb = int'(rx.rx_data_rdy) + int'(rx.frame_err);
`ifdef UART_RX_PARITY_EN
      nstb = nstb + int'(rx.parity_err);
      if (rx.parity_err) begin
        perr_seen++;
        take(K_PERR, "perr_event");
      end
`endif
      any = (nstb != 0);
      if (rx.rx_data_rdy) begin
        rdy_seen++;
        rdy_cyc.push_back(cyc);
        take(K_RDY, "rdy_event");
        chk("rdy_width", 32'(prev_rdy), 32'h0);
      end
      if (rx.frame_err) begin
        ferr_seen++;
        take(K_FERR, "ferr_event");
        chk("ferr_width", 32'(prev_ferr), 32'h0);
      end
      if (any) begin
        chk("one_strobe", 32'(nstb), 32'h1);
      end
      chk("rx_data_hold", 32'(rx.rx_data), 32'(model_data));
    end
    prev_rdy  = rx.rx_data_rdy;
    prev_ferr = rx.frame_err;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd = bits[i];
      idle(BIT_CLKS);
    end
    rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    send_raw({stop, ^d, d, 1'b0}, 11);
`else
    send_raw({1'b0, stop, d, 1'b0}, 10);
`endif
  endtask

  task automatic expect_evt(input logic [1:0] k, input logic [7:0] d);
    expq.push_back({k, d});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 3 * BIT_CLKS) begin
      idle(1);
      n++;
    end
    if (expq.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL %s: got %0d events pending, want 0",
               name, expq.size());
      expq.delete();
    end
    idle(2 * BIT_CLKS);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish by 3 ms, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c3;
    int gap;
    c3 = 8'hC3;
    @(negedge clk);
    idle(5);
    chk("reset_data", 32'(rx.rx_data), 32'h0);
    rst_n = 1'b1;
    idle(20);

    expect_evt(K_RDY, 8'h55);
    send_frame(8'h55, 1'b1);
    drain("t1_drain");
    chk("t1_rdy_count", 32'(rdy_seen), 32'd1);
    chk("t1_data", 32'(rx.rx_data), 32'h55);
    chk("t1_ferr_count", 32'(ferr_seen), 32'd0);

    expect_evt(K_RDY, 8'hA5);
    expect_evt(K_RDY, 8'h3C);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    drain("t2_drain");
    chk("t2_rdy_count", 32'(rdy_seen), 32'd3);
    chk("t2_data", 32'(rx.rx_data), 32'h3C);
    if (rdy_cyc.size() >= 3) begin
      gap = rdy_cyc[2] - rdy_cyc[1];
`ifdef UART_RX_PARITY_EN
      chk("t2_gap", 32'(gap >= 4744 && gap <= 4804), 32'd1);
`else
      chk("t2_gap", 32'(gap >= 4310 && gap <= 4370), 32'd1);
`endif
    end

    rxd = 1'b0;
    idle(150);
    rxd = 1'b1;
    idle(2 * BIT_CLKS);
    chk("t3_glitch_rdy", 32'(rdy_seen), 32'd3);
    expect_evt(K_RDY, 8'h81);
    send_frame(8'h81, 1'b1);
    drain("t3_drain");
    chk("t3_data", 32'(rx.rx_data), 32'h81);

    expect_evt(K_FERR, 8'h00);
    send_frame(8'hFF, 1'b0);
    rxd = 1'b0;
    idle(10_000);
    rxd = 1'b1;
    idle(2 * BIT_CLKS);
    chk("t4_ferr_count", 32'(ferr_seen), 32'd1);
    chk("t4_data_kept", 32'(rx.rx_data), 32'h81);
    expect_evt(K_RDY, 8'h12);
    send_frame(8'h12, 1'b1);
    drain("t4_drain");
    chk("t4_data", 32'(rx.rx_data), 32'h12);
    chk("t4_ferr_final", 32'(ferr_seen), 32'd1);
    chk("t4_rdy_count", 32'(rdy_seen), 32'd5);

    send_raw({6'b0, c3[3:0], 1'b0}, 5);
    rxd = c3[4];
    idle(217);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_async_data", 32'(rx.rx_data), 32'h0);
    chk("t5_async_rdy", 32'(rx.rx_data_rdy), 32'h0);
    idle(10);
    rxd = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(2 * BIT_CLKS);
    chk("t5_no_strobe", 32'(rdy_seen), 32'd5);
    expect_evt(K_RDY, 8'h7E);
    send_frame(8'h7E, 1'b1);
    drain("t5_drain");
    chk("t5_data", 32'(rx.rx_data), 32'h7E);

`ifdef UART_RX_PARITY_EN
    expect_evt(K_RDY, 8'h07);
    send_raw({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    drain("t6_good_drain");
    chk("t6_good_data", 32'(rx.rx_data), 32'h07);
    expect_evt(K_PERR, 8'h00);
    send_raw({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    drain("t6_bad_drain");
    chk("t6_perr_count", 32'(perr_seen), 32'd1);
    chk("t6_data_kept", 32'(rx.rx_data), 32'h07);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
